mem_stream_writer: RTL and testbench

//   Avalon-ST sink to Avalon-MM write master. Fills the 32-bit single-port on-chip RAM with a

---
 rtl/mem_stream_writer_pkg.sv | 39 +++
 rtl/msw_sync_fifo.sv | 61 ++++++
 rtl/mem_stream_writer.sv | 201 ++++++++++++++++++++
 tb/tb_mem_stream_writer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stream_writer_pkg.sv
// mem_stream_writer_pkg
//   Shared definitions for mem_stream_writer. Contents:
//   - CSR word offsets
//   - CONTROL and STATUS bit positions
//   - transfer FSM state type
//   - helper that packs the STATUS word
package mem_stream_writer_pkg;

  localparam logic [2:0] CSR_START_ADDR = 3'd0;
  localparam logic [2:0] CSR_LENGTH     = 3'd1;
  localparam logic [2:0] CSR_CONTROL    = 3'd2;
  localparam logic [2:0] CSR_STATUS     = 3'd3;
  localparam logic [2:0] CSR_CHECKSUM   = 3'd4;

  localparam int unsigned CTRL_GO_BIT    = 0;
  localparam int unsigned CTRL_ABORT_BIT = 1;

  localparam int unsigned STAT_BUSY_BIT    = 0;
  localparam int unsigned STAT_DONE_BIT    = 1;
  localparam int unsigned STAT_ABORTED_BIT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [31:0] pack_status(input logic busy, input logic done,
                                              input logic aborted, input logic [15:0] count);
    logic [31:0] s;
    s = '0;
    s[STAT_BUSY_BIT]    = busy;
    s[STAT_DONE_BIT]    = done;
    s[STAT_ABORTED_BIT] = aborted;
    s[31:16]            = count;
    return s;
  endfunction

endpackage

// File: rtl/msw_sync_fifo.sv
// msw_sync_fifo
//   Single-clock FIFO buffering stream words ahead of the RAM write port.
//   Pop data is presented combinationally from the head entry.
//   Ports:
//     clk, reset_n        clock, asynchronous active-low reset
//     push, push_data     write one entry (ignored when full unless popping too)
//     pop                 remove head entry (ignored when empty)
//     flush               discard all entries (wins over push/pop)
//     pop_data            head entry
//     full, empty         occupancy flags
module msw_sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra MSB on each pointer distinguishes full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign pop_data = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/mem_stream_writer.sv
// mem_stream_writer
//   Avalon-ST sink feeding an Avalon-MM write master. The master fills a
//   32-bit on-chip RAM one word per clock, starting at a programmable word
//   address and wrapping from MEM_DEPTH-1 to 0. Software drives it through a
//   small CSR slave.
//
//   Optional feature macro: MEM_STREAM_WRITER_CHECKSUM_EN. When it is defined,
//   a 32-bit wrapping sum of the written words is kept. The sum is readable at
//   CSR 4; otherwise CSR 4 reads 0.
//
//   Ports:
//     clk, reset_n                      clock, asynchronous active-low reset
//     csr_address/write/writedata/read  CSR slave; readdata valid cycle after read
//     csr_readdata                      CSR read data
//     snk_data/valid/ready              stream sink
//     m_address/byteenable/chipselect/write/writedata/clken
//                                       RAM master (no waitrequest)
module mem_stream_writer
  import mem_stream_writer_pkg::*;
#(
  parameter int unsigned MEM_DEPTH  = 2560,
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        csr_address,
  input  logic              csr_write,
  input  logic [31:0]       csr_writedata,
  input  logic              csr_read,
  output logic [31:0]       csr_readdata,
  input  logic [31:0]       snk_data,
  input  logic              snk_valid,
  output logic              snk_ready,
  output logic [ADDR_W-1:0] m_address,
  output logic [3:0]        m_byteenable,
  output logic              m_chipselect,
  output logic              m_write,
  output logic [31:0]       m_writedata,
  output logic              m_clken
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] start_eff;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       length;
  logic [15:0]       run_len;
  logic [15:0]       accepted;
  logic [15:0]       written;
  logic              aborted;
  logic              ctrl_wr;
  logic              go;
  logic              abort;
  logic              start;
  logic              flush;
  logic              pop;
  logic              push;
  logic              fifo_full;
  logic              fifo_empty;
  logic [31:0]       fifo_data;
  logic [31:0]       checksum_rd;
  logic              csr_wdata_unused;

  assign csr_wdata_unused = ^csr_writedata[31:16];

  assign m_byteenable = 4'hF;
  assign m_clken      = 1'b1;
  assign m_chipselect = m_write;

  assign ctrl_wr = csr_write && (csr_address == CSR_CONTROL);
  assign abort   = ctrl_wr && csr_writedata[CTRL_ABORT_BIT];
  // ABORT in the same write suppresses GO.
  assign go      = ctrl_wr && csr_writedata[CTRL_GO_BIT] && !csr_writedata[CTRL_ABORT_BIT];

  // Out-of-range start addresses are clamped to 0, not folded.
  assign start_eff = (32'(start_addr) >= MEM_DEPTH) ? '0 : start_addr;

  assign push = snk_valid && snk_ready;

  msw_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (snk_data),
    .pop       (pop),
    .flush     (flush),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    flush     = 1'b0;
    pop       = 1'b0;
    snk_ready = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (go) begin
          start     = 1'b1;
          flush     = 1'b1;
          state_nxt = (length == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          flush     = 1'b1;
          state_nxt = IDLE;
        end else begin
          snk_ready = !fifo_full && (accepted < run_len);
          pop       = !fifo_empty;
          // written counts pops, so equality is seen during the final m_write cycle.
          if (written == run_len) state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_write     <= 1'b0;
      m_address   <= '0;
      m_writedata <= '0;
      addr        <= '0;
      accepted    <= '0;
      written     <= '0;
      run_len     <= '0;
      aborted     <= 1'b0;
    end else begin
      m_write <= pop;
      if (pop) begin
        m_address   <= addr;
        m_writedata <= fifo_data;
        addr        <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
        written     <= written + 16'd1;
      end
      if (push) accepted <= accepted + 16'd1;
      if (start) begin
        accepted <= '0;
        written  <= '0;
        addr     <= start_eff;
        run_len  <= length;
        aborted  <= 1'b0;
      end
      if ((state == RUN) && abort) aborted <= 1'b1;
    end
  end

`ifdef MEM_STREAM_WRITER_CHECKSUM_EN
  logic [31:0] checksum;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   checksum <= '0;
    else if (start) checksum <= '0;
    else if (pop)   checksum <= checksum + fifo_data;
  end

  assign checksum_rd = checksum;
`else
  assign checksum_rd = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_addr <= '0;
      length     <= '0;
    end else if (csr_write) begin
      if (csr_address == CSR_START_ADDR) start_addr <= csr_writedata[ADDR_W-1:0];
      if (csr_address == CSR_LENGTH)     length     <= csr_writedata[15:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csr_readdata <= '0;
    end else if (csr_read) begin
      case (csr_address)
        CSR_START_ADDR: csr_readdata <= 32'(start_addr);
        CSR_LENGTH:     csr_readdata <= 32'(length);
        CSR_STATUS:     csr_readdata <= pack_status(state == RUN, state == DONE, aborted, written);
        CSR_CHECKSUM:   csr_readdata <= checksum_rd;
        default:        csr_readdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stream_writer.sv
module tb_mem_stream_writer;

  localparam int unsigned MEM_DEPTH = 2560;
  localparam int unsigned ADDR_W    = 12;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [2:0]        csr_address = '0;
  logic              csr_write = 1'b0;
  logic [31:0]       csr_writedata = '0;
  logic              csr_read = 1'b0;
  logic [31:0]       csr_readdata;
  logic [31:0]       snk_data = '0;
  logic              snk_valid = 1'b0;
  logic              snk_ready;
  logic [ADDR_W-1:0] m_address;
  logic [3:0]        m_byteenable;
  logic              m_chipselect;
  logic              m_write;
  logic [31:0]       m_writedata;
  logic              m_clken;

  mem_stream_writer #(
    .MEM_DEPTH  (MEM_DEPTH),
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (4)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .csr_address   (csr_address),
    .csr_write     (csr_write),
    .csr_writedata (csr_writedata),
    .csr_read      (csr_read),
    .csr_readdata  (csr_readdata),
    .snk_data      (snk_data),
    .snk_valid     (snk_valid),
    .snk_ready     (snk_ready),
    .m_address     (m_address),
    .m_byteenable  (m_byteenable),
    .m_chipselect  (m_chipselect),
    .m_write       (m_write),
    .m_writedata   (m_writedata),
    .m_clken       (m_clken)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  int          n_cmp = 0;
  int          n_err = 0;
  wr_t         exp_q[$];
  logic [31:0] src_q[$];
  longint      wcyc[$];
  longint      cyc = 0;
  int unsigned n_writes = 0;
  int unsigned cur_base = 0;
  int unsigned cur_idx = 0;
  logic [31:0] exp_sum = '0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] status_word(input int unsigned cnt, input logic aborted,
                                              input logic done, input logic busy);
    return {16'(cnt), 13'b0, aborted, done, busy};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every RAM write is matched against the next expected entry.
  always @(negedge clk) begin
    wr_t e;
    if (reset_n && m_write) begin
      n_writes++;
      wcyc.push_back(cyc);
      check("m_chipselect", 32'(m_chipselect), 32'd1);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got addr 0x%03h data 0x%08h, required no write",
                 m_address, m_writedata);
      end else begin
        e = exp_q.pop_front();
        check("m_address", 32'(m_address), 32'(e.addr));
        check("m_writedata", m_writedata, e.data);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
    csr_address   = a;
    csr_writedata = d;
    csr_write     = 1'b1;
    step();
    csr_write     = 1'b0;
  endtask

  task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
    csr_address = a;
    csr_read    = 1'b1;
    step();
    csr_read    = 1'b0;
    d           = csr_readdata;
  endtask

  task automatic start_xfer(input logic [31:0] start, input int unsigned len);
    logic [ADDR_W-1:0] s;
    s = start[ADDR_W-1:0];
    cur_base = (32'(s) >= MEM_DEPTH) ? 0 : 32'(s);
    cur_idx  = 0;
    exp_sum  = '0;
    wcyc.delete();
    csr_wr(3'd0, start);
    csr_wr(3'd1, 32'(len));
    csr_wr(3'd2, 32'h1);
  endtask

  task automatic fill_rand(input int unsigned n);
    repeat (n) src_q.push_back($urandom());
  endtask

  // mode 0: back-to-back, 1: valid every other cycle, 2: random valid
  task automatic send(input int mode);
    int guard;
    bit phase;
    bit v;
    logic [31:0] d;
    guard = 0;
    phase = 1'b0;
    while (src_q.size() > 0 && guard < 4000) begin
      if (mode == 0) v = 1'b1;
      else if (mode == 1) begin v = phase; phase = !phase; end
      else v = 1'($urandom_range(0, 1));
      d = src_q[0];
      snk_valid = v;
      snk_data  = d;
      if (v && snk_ready) begin
        exp_q.push_back({ADDR_W'((cur_base + cur_idx) % MEM_DEPTH), d});
        exp_sum = exp_sum + d;
        cur_idx++;
        void'(src_q.pop_front());
      end
      step();
      guard++;
    end
    snk_valid = 1'b0;
    check("send_all_accepted", src_q.size(), 32'd0);
    src_q.delete();
  endtask

  task automatic wait_done(input string name, input int unsigned cnt);
    logic [31:0] s;
    int k;
    k = 0;
    do begin
      csr_rd(3'd3, s);
      k++;
    end while (!s[1] && k < 200);
    check({name, "_status"}, s, status_word(cnt, 1'b0, 1'b1, 1'b0));
    check({name, "_drained"}, exp_q.size(), 32'd0);
    check({name, "_snk_ready"}, 32'(snk_ready), 32'd0);
    csr_rd(3'd4, s);
`ifdef MEM_STREAM_WRITER_CHECKSUM_EN
    check({name, "_checksum"}, s, exp_sum);
`else
    check({name, "_csr4"}, s, 32'd0);
`endif
  endtask

  initial begin
    logic [31:0] rd;
    int unsigned w0;
    int unsigned len;

    // Reset values
    #3;
    check("rst_m_write", 32'(m_write), 32'd0);
    check("rst_m_address", 32'(m_address), 32'd0);
    check("rst_m_writedata", m_writedata, 32'd0);
    check("rst_m_byteenable", 32'(m_byteenable), 32'hF);
    check("rst_m_clken", 32'(m_clken), 32'd1);
    check("rst_snk_ready", 32'(snk_ready), 32'd0);
    check("rst_csr_readdata", csr_readdata, 32'd0);
    repeat (2) step();
    reset_n = 1'b1;
    step();
    csr_rd(3'd3, rd); check("rst_status", rd, 32'd0);
    csr_rd(3'd0, rd); check("rst_start", rd, 32'd0);
    csr_rd(3'd1, rd); check("rst_length", rd, 32'd0);
    csr_wr(3'd3, 32'hFFFF_FFFF);
    csr_rd(3'd3, rd); check("status_write_ignored", rd, 32'd0);

    // START=0x010, LEN=4, words A0..A3 back-to-back
    start_xfer(32'h010, 4);
    src_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    send(0);
    wait_done("basic", 4);
    check("basic_nwrites", wcyc.size(), 32'd4);
    if (wcyc.size() == 4) check("basic_consecutive", 32'(wcyc[3] - wcyc[0]), 32'd3);
    csr_rd(3'd2, rd); check("control_reads_zero", rd, 32'd0);

    // Address wrap
    start_xfer(32'(MEM_DEPTH - 2), 4);
    fill_rand(4);
    send(0);
    wait_done("wrap", 4);

    // Alternating valid
    start_xfer(32'h123, 8);
    fill_rand(8);
    send(1);
    wait_done("alternate", 8);
    check("alternate_nwrites", wcyc.size(), 32'd8);

    // Abort after 3 words
    start_xfer(32'h100, 6);
    fill_rand(3);
    send(0);
    repeat (4) step();
    csr_wr(3'd2, 32'h2);
    w0 = n_writes;
    check("abort_snk_ready", 32'(snk_ready), 32'd0);
    csr_rd(3'd3, rd); check("abort_status", rd, status_word(3, 1'b1, 1'b0, 1'b0));
    snk_valid = 1'b1;
    repeat (5) step();
    check("abort_snk_ready_held", 32'(snk_ready), 32'd0);
    snk_valid = 1'b0;
    step();
    check("abort_no_writes", n_writes, w0);
    check("abort_drained", exp_q.size(), 32'd0);

    // Restart after abort
    start_xfer(32'h200, 5);
    fill_rand(5);
    send(2);
    wait_done("restart", 5);

    // LEN=0
    w0 = n_writes;
    start_xfer(32'h030, 0);
    csr_rd(3'd3, rd); check("len0_status", rd, status_word(0, 1'b0, 1'b1, 1'b0));
    repeat (4) step();
    check("len0_no_writes", n_writes, w0);

    // GO during RUN ignored
    start_xfer(32'h040, 6);
    fill_rand(3);
    send(0);
    repeat (4) step();
    csr_wr(3'd2, 32'h1);
    csr_rd(3'd3, rd); check("go_in_run_status", rd, status_word(3, 1'b0, 1'b0, 1'b1));
    fill_rand(3);
    send(2);
    wait_done("go_in_run", 6);

    // Start address beyond MEM_DEPTH clamps to 0
    start_xfer(32'hA05, 3);
    csr_rd(3'd0, rd); check("start_readback", rd, 32'hA05);
    fill_rand(3);
    send(0);
    wait_done("clamp", 3);

    // Checksum wrap: 1 + 2 + 0xFFFFFFFF
    start_xfer(32'h050, 3);
    src_q = '{32'h1, 32'h2, 32'hFFFF_FFFF};
    send(0);
    wait_done("sum", 3);
    csr_rd(3'd4, rd);
`ifdef MEM_STREAM_WRITER_CHECKSUM_EN
    check("sum_wrap", rd, 32'h2);
`else
    check("sum_disabled", rd, 32'h0);
`endif

    // Randomised transfers
    for (int i = 0; i < 8; i++) begin
      len = $urandom_range(1, 24);
      start_xfer($urandom_range(0, 4095), len);
      fill_rand(len);
      send($urandom_range(0, 2));
      wait_done("random", len);
    end

    // Reset mid-transfer
    start_xfer(32'h060, 10);
    fill_rand(3);
    send(0);
    reset_n = 1'b0;
    exp_q.delete();
    w0 = n_writes;
    #1;
    check("midrst_m_write", 32'(m_write), 32'd0);
    check("midrst_snk_ready", 32'(snk_ready), 32'd0);
    snk_valid = 1'b1;
    repeat (3) step();
    reset_n = 1'b1;
    repeat (3) step();
    check("midrst_snk_ready_after", 32'(snk_ready), 32'd0);
    snk_valid = 1'b0;
    csr_rd(3'd3, rd); check("midrst_status", rd, 32'd0);
    csr_rd(3'd1, rd); check("midrst_length", rd, 32'd0);
    check("midrst_no_writes", n_writes, w0);

    // Clean transfer after reset
    start_xfer(32'h070, 4);
    fill_rand(4);
    send(0);
    wait_done("post_reset", 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
